alu: RTL and testbench
======================

Name:
alu

Overview:
- 32-bit MIPS-style ALU used in the EX stage of the pipelined processor.
- Operands are rs data and a muxed rt-data/sign-extended immediate; the ALU control code selects the operation.
- Produces a result and a zero flag; the zero flag drives branch resolution.
- Result and flags are registered at the EX/MEM boundary, giving one clock of latency.

Parameters:
- WIDTH, 32, datapath width in bits. All arithmetic and width rules below scale with WIDTH.

Ports:
- clk  input  1  system clock; rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- rsdata  input  WIDTH  operand A (rs register data).
- rtdataOrextimm  input  WIDTH  operand B (rt register data or sign-extended immediate).
- ALUctrl  input  4  operation select.
- ALUResult  output  WIDTH  registered operation result.
- zero  output  1  registered flag; 1 when ALUResult is all zeros.
- overflow  output  1  registered signed-overflow flag for ADD/SUB.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - reset is asynchronous and active-high.
  - While reset is high: ALUResult=0, zero=1, overflow=0, regardless of clk.
  - Reset may assert at any time, including mid-operation. Release is sampled at the next rising edge.
- Latency:
  - Inputs are sampled on each rising clk edge when reset is low.
  - Outputs update one cycle later and hold until the next edge.
  - There is no handshake, stall, or enable. A new operation is accepted every cycle.
- Operation decode (ALUctrl):
  - 0000 AND: A & B.
  - 0001 OR: A | B.
  - 0010 ADD: A + B, modulo 2^WIDTH; carry-out discarded.
  - 0110 SUB: A - B, modulo 2^WIDTH.
  - 0111 SLT: 1 if A < B as two's-complement signed values, else 0. Result is zero-extended to WIDTH.
  - 1100 NOR: ~(A | B).
  - Any other code: result 0, overflow 0.
- Overflow flag:
  - ADD: set when A and B have equal sign bits and the sum sign differs from A.
  - SUB: set when A and B have differing sign bits and the difference sign differs from A.
  - SLT compares correctly even when A - B overflows: use the true signed comparison, not the raw subtraction sign.
  - overflow is 0 for all other operations.
- zero flag:
  - Computed from the same-cycle combinational result and registered alongside it.
  - Invariant at every edge and during reset: zero == (ALUResult == 0).
- Purity:
  - No internal state besides the output registers.
  - Identical inputs in consecutive cycles give identical outputs.
- Unknown-input handling:
  - An X or undefined ALUctrl must not latch; treat it as an unsupported code (result 0).

Test Plan:
- Reset check: assert reset asynchronously between clock edges -> outputs become ALUResult=0, zero=1, overflow=0 immediately. Release reset, then apply ADD 5+6 -> ALUResult=11 one edge later.
- Logic ops: AND 1,0 ctrl 0 -> 0, zero=1. OR 1,0 ctrl 1 -> 1, zero=0. NOR 0,0 ctrl 12 -> 0xFFFFFFFF, zero=0.
- Arithmetic: ADD 5,6 ctrl 2 -> 11, zero=0. SUB 5,5 ctrl 6 -> 0, zero=1. SUB 0,1 -> 0xFFFFFFFF, overflow=0.
- Overflow: ADD 0x7FFFFFFF,1 -> 0x80000000, overflow=1. SUB 0x80000000,1 -> 0x7FFFFFFF, overflow=1.
- SLT signed: 5,6 -> 1; 6,5 -> 0; 0xFFFFFFFF(-1),1 -> 1; 0x80000000,0x7FFFFFFF -> 1 (overflow case handled).
- Pipelining/unsupported codes: back-to-back ops on consecutive edges -> each result appears exactly one cycle after its inputs. ctrl 3, 15, or X -> ALUResult=0, zero=1, overflow=0.

Source files
------------

// File: rtl/alu.sv
// 32-bit MIPS-style EX-stage ALU with registered result, zero and overflow flags.
// One clock of latency; a new operation is accepted on every rising edge.
module alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] rsdata,
    input  logic [WIDTH-1:0] rtdataOrextimm,
    input  logic [3:0]       ALUctrl,
    output logic [WIDTH-1:0] ALUResult,
    output logic             zero,
    output logic             overflow
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             a_s;
    logic             b_s;
    logic             add_ovf;
    logic             sub_ovf;
    logic             slt;

    logic [WIDTH-1:0] result_d;
    logic [WIDTH-1:0] result_q;
    logic             zero_d;
    logic             zero_q;
    logic             ovf_d;
    logic             ovf_q;

    assign a    = rsdata;
    assign b    = rtdataOrextimm;
    assign sum  = a + b;
    assign diff = a - b;
    assign a_s  = a[WIDTH-1];
    assign b_s  = b[WIDTH-1];

    assign add_ovf = (a_s == b_s) && (sum[WIDTH-1] != a_s);
    assign sub_ovf = (a_s != b_s) && (diff[WIDTH-1] != a_s);

    // Differing signs decide the order directly, so an overflowing
    // subtraction can never corrupt the comparison.
    assign slt = (a_s != b_s) ? a_s : diff[WIDTH-1];

    always_comb begin
        result_d = '0;
        ovf_d    = 1'b0;
        case (ALUctrl)
            OP_AND: result_d = a & b;
            OP_OR:  result_d = a | b;
            OP_ADD: begin
                result_d = sum;
                ovf_d    = add_ovf;
            end
            OP_SUB: begin
                result_d = diff;
                ovf_d    = sub_ovf;
            end
            OP_SLT: result_d = {{(WIDTH-1){1'b0}}, slt};
            OP_NOR: result_d = ~(a | b);
            default: begin
                result_d = '0;
                ovf_d    = 1'b0;
            end
        endcase
        zero_d = (result_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q <= '0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    assign ALUResult = result_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_alu.sv
// Bench for alu: directed literal cases plus randomized traffic checked
// every cycle against a signed-arithmetic reference model.
module tb_alu;

    logic        clk;
    logic        reset;
    logic [31:0] rsdata;
    logic [31:0] rtdataOrextimm;
    logic [3:0]  ALUctrl;
    logic [31:0] ALUResult;
    logic        zero;
    logic        overflow;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    alu #(.WIDTH(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .rsdata         (rsdata),
        .rtdataOrextimm (rtdataOrextimm),
        .ALUctrl        (ALUctrl),
        .ALUResult      (ALUResult),
        .zero           (zero),
        .overflow       (overflow)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic [3:0] c,
                                  output logic [31:0] r, output logic o);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint t;
        r = 32'd0;
        o = 1'b0;
        case (c)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2: begin
                t = sa + sb;
                r = t[31:0];
                o = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            4'd6: begin
                t = sa - sb;
                r = t[31:0];
                o = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            4'd7:  r = (sa < sb) ? 32'd1 : 32'd0;
            4'd12: r = ~(a | b);
            default: begin
                r = 32'd0;
                o = 1'b0;
            end
        endcase
    endfunction

    task automatic chk(input string name, input logic [33:0] got,
                       input logic [33:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got res=%h zero=%b ovf=%b, want res=%h zero=%b ovf=%b",
                     name, got[33:2], got[1], got[0], exp[33:2], exp[1], exp[0]);
        end
    endtask

    always @(posedge clk) begin
        logic [31:0] er;
        logic        eo;
        logic        rs;
        if (chk_en) begin
            rs = reset;
            model(rsdata, rtdataOrextimm, ALUctrl, er, eo);
            if (rs) begin
                er = 32'd0;
                eo = 1'b0;
            end
            #1;
            chk("model", {ALUResult, zero, overflow}, {er, (er == 32'd0), eo});
        end
    end

    task automatic op(input string name, input logic [31:0] a,
                      input logic [31:0] b, input logic [3:0] c,
                      input logic [31:0] er, input logic ez, input logic eo);
        @(negedge clk);
        rsdata         = a;
        rtdataOrextimm = b;
        ALUctrl        = c;
        @(posedge clk);
        #1;
        chk(name, {ALUResult, zero, overflow}, {er, ez, eo});
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'h7FFF_FFFF;
            1: v = 32'h8000_0000;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'd0;
            4: v = 32'd1;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        logic [3:0] codes [8];
        codes = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd2, 4'd6};
        reset          = 1;
        rsdata         = 0;
        rtdataOrextimm = 0;
        ALUctrl        = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_state", {ALUResult, zero, overflow}, {32'd0, 1'b1, 1'b0});
        @(negedge clk);
        reset  = 0;
        chk_en = 1;

        op("add_5_6",     32'd5, 32'd6, 4'd2,  32'd11, 1'b0, 1'b0);
        op("and_1_0",     32'd1, 32'd0, 4'd0,  32'd0,  1'b1, 1'b0);
        op("or_1_0",      32'd1, 32'd0, 4'd1,  32'd1,  1'b0, 1'b0);
        op("nor_0_0",     32'd0, 32'd0, 4'd12, 32'hFFFF_FFFF, 1'b0, 1'b0);
        op("sub_5_5",     32'd5, 32'd5, 4'd6,  32'd0,  1'b1, 1'b0);
        op("sub_0_1",     32'd0, 32'd1, 4'd6,  32'hFFFF_FFFF, 1'b0, 1'b0);
        op("add_ovf",     32'h7FFF_FFFF, 32'd1, 4'd2, 32'h8000_0000, 1'b0, 1'b1);
        op("sub_ovf",     32'h8000_0000, 32'd1, 4'd6, 32'h7FFF_FFFF, 1'b0, 1'b1);
        op("slt_5_6",     32'd5, 32'd6, 4'd7,  32'd1,  1'b0, 1'b0);
        op("slt_6_5",     32'd6, 32'd5, 4'd7,  32'd0,  1'b1, 1'b0);
        op("slt_m1_1",    32'hFFFF_FFFF, 32'd1, 4'd7, 32'd1, 1'b0, 1'b0);
        op("slt_min_max", 32'h8000_0000, 32'h7FFF_FFFF, 4'd7, 32'd1, 1'b0, 1'b0);
        op("slt_max_min", 32'h7FFF_FFFF, 32'h8000_0000, 4'd7, 32'd0, 1'b1, 1'b0);
        op("ctrl3",       32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd3,  32'd0, 1'b1, 1'b0);
        op("ctrl15",      32'h7FFF_FFFF, 32'd1, 4'd15, 32'd0, 1'b1, 1'b0);

        op("pre_reset",   32'h7FFF_FFFF, 32'd1, 4'd2, 32'h8000_0000, 1'b0, 1'b1);
        #2;
        reset = 1;
        #1;
        chk("async_reset", {ALUResult, zero, overflow}, {32'd0, 1'b1, 1'b0});
        @(negedge clk);
        reset = 0;
        op("post_reset",  32'd5, 32'd6, 4'd2, 32'd11, 1'b0, 1'b0);

        repeat (600) begin
            @(negedge clk);
            rsdata         = pick();
            rtdataOrextimm = pick();
            if ($urandom_range(0, 9) == 0)
                ALUctrl = 4'($urandom);
            else
                ALUctrl = codes[$urandom_range(0, 7)];
        end

        @(negedge clk);
        chk_en = 0;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
